// File: rtl/skewed_memory_bank_pkg.sv
// Shared types and width helpers for the skewed column-bank memory.
// Sequencer states and address/length width derivation from bank depth.
package skewed_memory_bank_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } seq_state_e;

  function automatic int calcAddrWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // One extra bit so a length equal to depth (and beyond, before clamping) fits.
  function automatic int calcLenWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/skew_bank_column.sv
// One memory bank with an independent write port, a registered read port and
// a lane-dependent delay line that skews data and valid together.
module skew_bank_column
  import skewed_memory_bank_pkg::*;
#(
  parameter int  dataSize  = 16,
  parameter int  depth     = 8,
  parameter int  lane      = 0,
  localparam int addrWidth = calcAddrWidth(depth)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        writeEnable,
  input  logic signed [dataSize-1:0]  writeElement,
  input  logic        [addrWidth-1:0] writeLocation,
  input  logic                        readEnable,
  input  logic        [addrWidth-1:0] readLocation,
  output logic signed [dataSize-1:0]  outputElement,
  output logic                        outputValid
);

  logic signed [dataSize-1:0] r_mem [depth];
  logic signed [dataSize-1:0] r_rdData_p0;
  logic                       r_vld_p0;

  // Bank storage is deliberately outside reset so contents survive an abort.
  always_ff @(posedge clk) begin
    if (writeEnable) begin
      r_mem[writeLocation] <= writeElement;
    end
  end

  // Read stage: a same-cycle write to this address is not yet visible here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdData_p0 <= '0;
      r_vld_p0    <= 1'b0;
    end else begin
      r_vld_p0    <= readEnable;
      r_rdData_p0 <= readEnable ? r_mem[readLocation] : '0;
    end
  end

  generate
    if (lane == 0) begin : g_noSkew
      assign outputElement = r_rdData_p0;
      assign outputValid   = r_vld_p0;
    end else begin : g_skew
      logic signed [dataSize-1:0] r_skewData_p1 [lane];
      logic        [lane-1:0]     r_skewVld_p1;

      // Skew stages: zeros entering behind a stream keep idle lanes padded.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int s = 0; s < lane; s++) begin
            r_skewData_p1[s] <= '0;
          end
          r_skewVld_p1 <= '0;
        end else begin
          r_skewData_p1[0] <= r_rdData_p0;
          r_skewVld_p1[0]  <= r_vld_p0;
          for (int s = 1; s < lane; s++) begin
            r_skewData_p1[s] <= r_skewData_p1[s-1];
            r_skewVld_p1[s]  <= r_skewVld_p1[s-1];
          end
        end
      end

      assign outputElement = r_skewData_p1[lane-1];
      assign outputValid   = r_skewVld_p1[lane-1];
    end
  endgenerate

endmodule

// File: rtl/skewed_memory_bank.sv
// Multi-bank column memory with a start/length row sequencer whose lanes are
// diagonally skewed for direct consumption by a systolic array edge.
module skewed_memory_bank
  import skewed_memory_bank_pkg::*;
#(
  parameter int  matrixSize = 4,
  parameter int  dataSize   = 16,
  parameter int  depth      = 8,
  localparam int addrWidth  = calcAddrWidth(depth),
  localparam int lenWidth   = calcLenWidth(depth)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic        [matrixSize-1:0] writeEnableVector,
  input  logic signed [dataSize-1:0]  writeElementVector  [matrixSize],
  input  logic        [addrWidth-1:0] writeLocationVector [matrixSize],
  input  logic                        start,
  input  logic        [addrWidth-1:0] startAddr,
  input  logic        [lenWidth-1:0]  length,
  output logic                        busy,
  output logic                        done,
  output logic signed [dataSize-1:0]  outputElementVector [matrixSize],
  output logic        [matrixSize-1:0] outputValidVector
);

  localparam int                   cntWidth = (matrixSize > 1) ? $clog2(matrixSize) : 1;
  localparam logic [lenWidth-1:0]  lenDepth = lenWidth'(depth);
  localparam logic [addrWidth-1:0] addrLast = addrWidth'(depth - 1);
  localparam logic [cntWidth-1:0]  cntLast  = cntWidth'(matrixSize - 1);

  seq_state_e           r_state, w_stateNext;
  logic [addrWidth-1:0] r_ptr, w_ptrNext;
  logic [lenWidth-1:0]  r_remaining, w_remainingNext;
  logic [cntWidth-1:0]  r_drainCnt, w_drainCntNext;
  logic                 w_readEnable;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_remaining <= '0;
      r_drainCnt  <= '0;
    end else begin
      r_state     <= w_stateNext;
      r_ptr       <= w_ptrNext;
      r_remaining <= w_remainingNext;
      r_drainCnt  <= w_drainCntNext;
    end
  end

  always_comb begin
    w_stateNext     = r_state;
    w_ptrNext       = r_ptr;
    w_remainingNext = r_remaining;
    w_drainCntNext  = r_drainCnt;
    w_readEnable    = 1'b0;
    busy            = (r_state != IDLE);
    done            = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && (length != '0)) begin
          w_stateNext     = STREAM;
          w_ptrNext       = startAddr;
          w_remainingNext = (length > lenDepth) ? lenDepth : length;
          w_drainCntNext  = '0;
        end
      end
      STREAM: begin
        w_readEnable    = 1'b1;
        w_ptrNext       = (r_ptr == addrLast) ? '0 : r_ptr + addrWidth'(1);
        w_remainingNext = r_remaining - lenWidth'(1);
        if (r_remaining == lenWidth'(1)) begin
          w_stateNext    = DRAIN;
          w_drainCntNext = '0;
        end
      end
      DRAIN: begin
        // The last lane's final row emerges exactly as the count tops out.
        w_drainCntNext = r_drainCnt + cntWidth'(1);
        if (r_drainCnt == cntLast) begin
          done        = 1'b1;
          w_stateNext = IDLE;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  generate
    for (genvar g = 0; g < matrixSize; g++) begin : g_lane
      skew_bank_column #(
        .dataSize(dataSize),
        .depth   (depth),
        .lane    (g)
      ) u_column (
        .clk          (clk),
        .rst          (rst),
        .writeEnable  (writeEnableVector[g]),
        .writeElement (writeElementVector[g]),
        .writeLocation(writeLocationVector[g]),
        .readEnable   (w_readEnable),
        .readLocation (r_ptr),
        .outputElement(outputElementVector[g]),
        .outputValid  (outputValidVector[g])
      );
    end
  endgenerate

endmodule

// File: tb/tb_skewed_memory_bank.sv
// Randomised and directed bench for skewed_memory_bank against an
// edge-by-edge reference built from row/lane timing rules.
module tb_skewed_memory_bank;
  localparam int M = 4, W = 16, D = 8, AW = 3, LW = 4, RING = 64;

  logic                clk = 1'b0;
  logic                rst;
  logic        [M-1:0] writeEnableVector;
  logic signed [W-1:0] writeElementVector  [M];
  logic        [AW-1:0] writeLocationVector [M];
  logic                start;
  logic        [AW-1:0] startAddr;
  logic        [LW-1:0] length;
  logic                busy, done;
  logic signed [W-1:0] outputElementVector [M];
  logic        [M-1:0] outputValidVector;

  skewed_memory_bank #(.matrixSize(M), .dataSize(W), .depth(D)) dut (
    .clk(clk), .rst(rst),
    .writeEnableVector(writeEnableVector),
    .writeElementVector(writeElementVector),
    .writeLocationVector(writeLocationVector),
    .start(start), .startAddr(startAddr), .length(length),
    .busy(busy), .done(done),
    .outputElementVector(outputElementVector),
    .outputValidVector(outputValidVector)
  );

  always #5 clk = ~clk;

  int nTests = 0, nFail = 0, cyc = 0;

  logic signed [W-1:0] mMem  [M][D];
  logic signed [W-1:0] ringD [RING][M];
  logic                ringV [RING][M];
  bit mActive = 0, mBusy = 0;
  int mS = 0, mA = 0, mL = 0;
  logic signed [W-1:0] eData [M];
  logic eVld [M];
  logic eBusy, eDone;

  // Advance one edge; the model sees the same inputs the DUT samples there.
  task automatic tick();
    int n;
    int k;
    @(posedge clk);
    cyc++;
    n = cyc;
    if (rst) begin
      for (int c = 0; c < RING; c++)
        for (int i = 0; i < M; i++) begin ringD[c][i] = '0; ringV[c][i] = 1'b0; end
      mActive = 0; mBusy = 0; eBusy = 1'b0; eDone = 1'b0;
    end else begin
      if (mActive && n >= mS + 1 && n <= mS + mL) begin
        k = n - mS - 1;
        for (int i = 0; i < M; i++) begin
          ringD[(n + i) % RING][i] = mMem[i][(mA + k) % D];
          ringV[(n + i) % RING][i] = 1'b1;
        end
      end
      if (!mBusy && start && length != 0) begin
        mActive = 1; mS = n; mA = int'(startAddr);
        mL = (int'(length) > D) ? D : int'(length);
      end
      eBusy = mActive && (n <= mS + mL + M - 1);
      eDone = mActive && (n == mS + mL + M - 1);
      mActive = eBusy;
      mBusy = eBusy;
    end
    for (int i = 0; i < M; i++)
      if (writeEnableVector[i]) mMem[i][writeLocationVector[i]] = writeElementVector[i];
    for (int i = 0; i < M; i++) begin
      eData[i] = ringD[n % RING][i];
      eVld[i]  = ringV[n % RING][i];
      ringD[n % RING][i] = '0;
      ringV[n % RING][i] = 1'b0;
    end
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; startAddr = '0; length = '0; writeEnableVector = '0;
    for (int i = 0; i < M; i++) begin writeElementVector[i] = '0; writeLocationVector[i] = '0; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick(); tick();
    nTests++;
    if (busy !== 1'b0 || done !== 1'b0 || outputValidVector !== '0) begin
      nFail++; $display("FAIL reset_ctrl busy=%b done=%b vld=%b expected 0 0 0000", busy, done, outputValidVector);
    end
    for (int i = 0; i < M; i++) begin
      nTests++;
      if (outputElementVector[i] !== '0) begin
        nFail++; $display("FAIL reset_data lane%0d got %0d expected 0", i, outputElementVector[i]);
      end
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write_and_stream();
    int s = 0, doneCyc = -1, lastBusy = -1;
    int vcnt [M];
    for (int r = 0; r < D; r++) begin
      writeEnableVector = '1;
      for (int b = 0; b < M; b++) begin
        writeElementVector[b] = W'(100 * b + r); writeLocationVector[b] = AW'(r);
      end
      tick();
    end
    idle_inputs();
    for (int i = 0; i < M; i++) vcnt[i] = 0;
    for (int c = 0; c < 14; c++) begin
      start = (c == 0); startAddr = 3'd0; length = 4'd4;
      tick();
      if (c == 0) s = cyc;
      if (done) doneCyc = cyc;
      if (busy) lastBusy = cyc;
      nTests++;
      if (busy !== eBusy || done !== eDone) begin
        nFail++; $display("FAIL stream_ctrl cyc=%0d busy/done=%b%b expected %b%b", cyc, busy, done, eBusy, eDone);
      end
      for (int i = 0; i < M; i++) begin
        if (outputValidVector[i]) vcnt[i]++;
        nTests++;
        if (outputValidVector[i] !== eVld[i] || outputElementVector[i] !== eData[i]) begin
          nFail++; $display("FAIL stream_lane%0d cyc=%0d got v=%b d=%0d expected v=%b d=%0d", i, cyc, outputValidVector[i], outputElementVector[i], eVld[i], eData[i]);
        end
      end
    end
    nTests++;
    if (doneCyc != s + 7 || lastBusy != s + 7) begin
      nFail++; $display("FAIL stream_timing done_at=+%0d last_busy=+%0d expected +7 +7", doneCyc - s, lastBusy - s);
    end
    for (int i = 0; i < M; i++) begin
      nTests++;
      if (vcnt[i] != 4) begin nFail++; $display("FAIL stream_vcount lane%0d got %0d expected 4", i, vcnt[i]); end
    end
  endtask

  task automatic test_wrap();
    int got [$];
    idle_inputs();
    for (int c = 0; c < 12; c++) begin
      start = (c == 0); startAddr = 3'd6; length = 4'd4;
      tick();
      if (outputValidVector[M-1]) got.push_back(int'(outputElementVector[M-1]));
      nTests++;
      if (busy !== eBusy || done !== eDone) begin
        nFail++; $display("FAIL wrap_ctrl cyc=%0d busy/done=%b%b expected %b%b", cyc, busy, done, eBusy, eDone);
      end
      for (int i = 0; i < M; i++) begin
        nTests++;
        if (outputValidVector[i] !== eVld[i] || outputElementVector[i] !== eData[i]) begin
          nFail++; $display("FAIL wrap_lane%0d cyc=%0d got v=%b d=%0d expected v=%b d=%0d", i, cyc, outputValidVector[i], outputElementVector[i], eVld[i], eData[i]);
        end
      end
    end
    nTests++;
    if (got.size() != 4 || got[0] != 306 || got[1] != 307 || got[2] != 300 || got[3] != 301) begin
      nFail++; $display("FAIL wrap_rows lane3 got %p expected 306 307 300 301", got);
    end
  endtask

  task automatic test_clamp_zero();
    int vcnt [M];
    int zbusy = 0;
    idle_inputs();
    for (int c = 0; c < 5; c++) begin
      start = (c == 0); length = 4'd0;
      tick();
      if (busy || done) zbusy++;
    end
    nTests++;
    if (zbusy != 0) begin nFail++; $display("FAIL zero_len busy_or_done_cycles=%0d expected 0", zbusy); end
    for (int i = 0; i < M; i++) vcnt[i] = 0;
    for (int c = 0; c < 16; c++) begin
      start = (c == 0); startAddr = 3'd2; length = 4'd12;
      tick();
      nTests++;
      if (busy !== eBusy || done !== eDone) begin
        nFail++; $display("FAIL clamp_ctrl cyc=%0d busy/done=%b%b expected %b%b", cyc, busy, done, eBusy, eDone);
      end
      for (int i = 0; i < M; i++) begin
        if (outputValidVector[i]) vcnt[i]++;
        nTests++;
        if (outputValidVector[i] !== eVld[i] || outputElementVector[i] !== eData[i]) begin
          nFail++; $display("FAIL clamp_lane%0d cyc=%0d got v=%b d=%0d expected v=%b d=%0d", i, cyc, outputValidVector[i], outputElementVector[i], eVld[i], eData[i]);
        end
      end
    end
    for (int i = 0; i < M; i++) begin
      nTests++;
      if (vcnt[i] != 8) begin nFail++; $display("FAIL clamp_vcount lane%0d got %0d expected 8", i, vcnt[i]); end
    end
  endtask

  task automatic test_collision();
    int s = 0;
    for (int run = 0; run < 2; run++) begin
      idle_inputs();
      for (int c = 0; c < 12; c++) begin
        start = (c == 0); startAddr = 3'd0; length = 4'd4;
        writeEnableVector = (run == 0 && c == 3) ? 4'b0010 : 4'b0000;
        writeElementVector[1] = 16'sh7FFF; writeLocationVector[1] = 3'd2;
        tick();
        if (c == 0) s = cyc;
        if (c == 4) begin
          nTests++;
          if (outputValidVector[1] !== 1'b1 || outputElementVector[1] !== ((run == 0) ? 16'sd102 : 16'sh7FFF)) begin
            nFail++; $display("FAIL collision_run%0d lane1 got v=%b d=%0d expected v=1 d=%0d", run, outputValidVector[1], outputElementVector[1], (run == 0) ? 102 : 32767);
          end
        end
        nTests++;
        if (busy !== eBusy || done !== eDone || outputValidVector[1] !== eVld[1] || outputElementVector[1] !== eData[1]) begin
          nFail++; $display("FAIL collision_model cyc=%0d busy/done=%b%b v=%b d=%0d expected %b%b v=%b d=%0d", cyc, busy, done, outputValidVector[1], outputElementVector[1], eBusy, eDone, eVld[1], eData[1]);
        end
      end
    end
  endtask

  task automatic test_ignored_start();
    int v0 = 0, nDone = 0;
    idle_inputs();
    for (int c = 0; c < 18; c++) begin
      start = (c <= 6); startAddr = (c == 0) ? 3'd0 : 3'd5; length = (c == 0) ? 4'd4 : 4'd8;
      tick();
      if (outputValidVector[0]) v0++;
      if (done) nDone++;
      nTests++;
      if (busy !== eBusy || done !== eDone || outputValidVector[0] !== eVld[0] || outputElementVector[0] !== eData[0]) begin
        nFail++; $display("FAIL ignored_model cyc=%0d busy/done=%b%b v=%b d=%0d expected %b%b v=%b d=%0d", cyc, busy, done, outputValidVector[0], outputElementVector[0], eBusy, eDone, eVld[0], eData[0]);
      end
    end
    nTests++;
    if (v0 != 4 || nDone != 1) begin
      nFail++; $display("FAIL ignored_start lane0_valids=%0d dones=%0d expected 4 1", v0, nDone);
    end
  endtask

  task automatic test_reset_mid();
    int nDone = 0;
    idle_inputs();
    for (int c = 0; c < 16; c++) begin
      start = (c == 0); startAddr = 3'd0; length = 4'd8; rst = (c == 4);
      tick();
      if (done) nDone++;
      if (c == 4) begin
        nTests++;
        if (busy !== 1'b0 || done !== 1'b0 || outputValidVector !== '0 || outputElementVector[0] !== '0 || outputElementVector[M-1] !== '0) begin
          nFail++; $display("FAIL reset_mid busy=%b done=%b vld=%b d0=%0d d3=%0d expected all 0", busy, done, outputValidVector, outputElementVector[0], outputElementVector[M-1]);
        end
      end
    end
    rst = 1'b0;
    nTests++;
    if (nDone != 0) begin nFail++; $display("FAIL reset_mid_done got %0d expected 0", nDone); end
    for (int c = 0; c < 14; c++) begin
      start = (c == 0);
      tick();
      for (int i = 0; i < M; i++) begin
        nTests++;
        if (outputValidVector[i] !== eVld[i] || outputElementVector[i] !== eData[i]) begin
          nFail++; $display("FAIL reset_preserve lane%0d cyc=%0d got v=%b d=%0d expected v=%b d=%0d", i, cyc, outputValidVector[i], outputElementVector[i], eVld[i], eData[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    idle_inputs();
    for (int c = 0; c < 420; c++) begin
      if (c < 400) begin
        start = ($urandom_range(0, 2) == 0);
        startAddr = AW'($urandom_range(0, D - 1));
        length = LW'($urandom_range(0, 12));
        writeEnableVector = M'($urandom);
        for (int i = 0; i < M; i++) begin
          writeElementVector[i] = W'($urandom); writeLocationVector[i] = AW'($urandom_range(0, D - 1));
        end
      end else begin
        idle_inputs();
      end
      tick();
      nTests++;
      if (busy !== eBusy || done !== eDone) begin
        nFail++; $display("FAIL random_ctrl cyc=%0d busy/done=%b%b expected %b%b", cyc, busy, done, eBusy, eDone);
      end
      for (int i = 0; i < M; i++) begin
        nTests++;
        if (outputValidVector[i] !== eVld[i] || outputElementVector[i] !== eData[i]) begin
          nFail++; $display("FAIL random_lane%0d cyc=%0d got v=%b d=%0d expected v=%b d=%0d", i, cyc, outputValidVector[i], outputElementVector[i], eVld[i], eData[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_and_stream();
    test_wrap();
    test_clamp_zero();
    test_collision();
    test_ignored_start();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/skewed_memory_bank.md
# skewed_memory_bank

Parametrised successor to the column-bank memory that feeds the systolic array. It holds `matrixSize` independent banks of `depth` entries, each with its own write enable. A start/length sequencer streams a run of rows out of all banks, applying a per-lane diagonal skew so that lane `i` lags lane 0 by `i` cycles. Every output carries a per-lane valid, and lanes are zero-padded outside their window, so the array edge can consume the outputs directly.

## Interface
- `matrixSize`, 4: number of banks/lanes (≥2).
- `dataSize`, 16: signed element width.
- `depth`, 8: entries per bank (≥2). Derived `addrWidth = $clog2(depth)`, `lenWidth = $clog2(depth)+1`.

- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `writeEnableVector`  in  1 ×[matrixSize]  per-bank write enable.
- `writeElementVector`  in  signed dataSize ×[matrixSize]  write data per bank.
- `writeLocationVector`  in  addrWidth ×[matrixSize]  write address per bank.
- `start`  in  1  stream request; honoured only when `busy`=0.
- `startAddr`  in  addrWidth  first row to read.
- `length`  in  lenWidth  rows to stream.
- `busy`  out  1  sequencer active.
- `done`  out  1  one-cycle pulse marking completion.
- `outputElementVector`  out  signed dataSize ×[matrixSize]  skewed lane data.
- `outputValidVector`  out  1 ×[matrixSize]  per-lane valid.

## Operation
- **Writes**
  - Independent per bank and accepted in every state, including during a stream.
  - Same-cycle write and read to the same bank/address returns the OLD data (read-before-write).
- **States** (`IDLE`, `STREAM`, `DRAIN`):
  - `IDLE`, `start`=1, `length`≥1: latch `ptr=startAddr` and `remaining=min(length,depth)`, set `busy`, go to `STREAM`.
  - `IDLE`, `start`=1, `length`=0: ignored. `busy` stays 0 and no `done` is issued.
  - `STREAM`: each cycle, read address `ptr` from all banks, `ptr` increments modulo `depth` (wraps `depth-1`→0), `remaining` decrements. When the last row is issued, go to `DRAIN`.
  - `DRAIN`: count `matrixSize` cycles to flush the skew pipeline, then return to `IDLE`.
  - `start` while `busy`=1 is ignored. It is not queued.
- **Skew**
  - Lane 0 output is the registered bank read.
  - Lane `i` passes through `i` additional register stages. Data and valid are skewed together.
- **Zero-padding:** when a lane's valid is 0, its output element is 0.
- **Reset**
  - Clears state to `IDLE` and zeroes `busy`, `done`, all valids, all outputs and all skew stages.
  - Bank contents are NOT reset.
  - Reset mid-stream aborts the stream with no `done`.

## Timing
- Edge 0 samples `start`.
- Row `k` (0-based) of lane `i` is visible after edge `1+k+i`, with lane valid high for exactly `L` consecutive cycles (`L` = clamped length).
- Final valid output is lane `matrixSize-1`, row `L-1`, after edge `L+matrixSize-1`.
- `done` is high in that same cycle, for one cycle only.
- `busy` is high from after edge 0 through the `done` cycle and falls after edge `L+matrixSize`.
- Next `start` is accepted at the first edge where `busy`=0 (back-to-back minimum gap: 0 idle cycles after `busy` falls).
- Write latency: data written at edge `t` is readable by a stream read issued in cycle `t+1`.

## Structure
- Package `skewed_memory_bank_pkg`:
  - State enum typedef (`IDLE`, `STREAM`, `DRAIN`).
  - Helper functions for `addrWidth`/`lenWidth`.
- Sub-module `skew_bank_column`: one bank with write port and registered read port, plus a parametrised `i`-stage skew delay for data and valid. Instantiated `matrixSize` times by a generate loop.
- Sequencer FSM, pointer and counters live in the top level.

## Test plan
- **Write and stream:** write bank `b` row `r` = `100*b+r` (4×8); start `startAddr=0`, `length=4` → lane `i` shows `100*i+0..3` after edges `1+i..4+i`; `done` after edge 7; `busy` falls after edge 8.
- **Wrap-around:** `startAddr=6`, `length=4`, depth 8 → rows 6,7,0,1 on every lane.
- **Clamp and zero-length:** `length=0` → no `busy`, no `done`; `length=12` → exactly 8 valids per lane.
- **Read/write collision:** write row 2 of bank 1 with 0x7FFF in the same cycle the stream reads row 2 → lane 1 outputs the old value; a later stream outputs 0x7FFF.
- **Ignored start:** assert `start` while `busy`=1 → no effect on the current stream and no extra run.
- **Reset mid-stream:** assert `rst` after edge 3 of a length-8 stream → all outputs/valids 0 and `busy`=0 next cycle, no `done`; bank contents are preserved in the following stream.
